// File: rtl/cpu_pkg.sv
// Shared types and constants for the control unit: opcodes, FSM states,
// fault codes and instruction field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    OpNop   = 4'd0,
    OpLdi   = 4'd1,
    OpAlu   = 4'd2,
    OpPushi = 4'd3,
    OpPusha = 4'd4,
    OpPop   = 4'd5,
    OpJmp   = 4'd6,
    OpJc    = 4'd7,
    OpHalt  = 4'd8
  } opcode_e;

  // Highest legal opcode value; anything above decodes as illegal.
  localparam logic [3:0] OpLastLegal = 4'd8;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StHalt,
    StError
  } state_e;

  localparam logic [1:0] ErrNone      = 2'd0;
  localparam logic [1:0] ErrOverflow  = 2'd1;
  localparam logic [1:0] ErrUnderflow = 2'd2;
  localparam logic [1:0] ErrIllegal   = 2'd3;

  localparam int unsigned OpMsb   = 15;
  localparam int unsigned OpLsb   = 12;
  localparam int unsigned RselBit = 8;
  localparam int unsigned ImmMsb  = 7;
  localparam int unsigned ImmLsb  = 0;
  localparam int unsigned AluMsb  = 4;
  localparam int unsigned AluLsb  = 0;

  // Decoded control bundle; op is forced to OpNop when illegal is set.
  typedef struct packed {
    opcode_e    op;
    logic       illegal;
    logic       rsel;
    logic [7:0] imm;
    logic [4:0] alu_fn;
  } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits the instruction register into
// the control bundle used by the sequencer.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned IW = 16
) (
  input  logic [IW-1:0] ir,
  output ctrl_t         ctrl
);

  logic [3:0] op_raw;
  // Bits 11:9 are reserved in the encoding and carry no meaning.
  logic       unused_bits;

  assign op_raw      = ir[OpMsb:OpLsb];
  assign unused_bits = ^ir[11:9];

  // Field extraction and legality check
  always_comb begin
    ctrl         = '0;
    ctrl.op      = OpNop;
    ctrl.illegal = 1'b0;
    ctrl.rsel    = ir[RselBit];
    ctrl.imm     = ir[ImmMsb:ImmLsb];
    ctrl.alu_fn  = ir[AluMsb:AluLsb];
    if (op_raw <= OpLastLegal) begin
      ctrl.op = opcode_e'(op_raw);
    end else begin
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Three-cycle-per-instruction sequencer (fetch / decode / execute) driving a
// register file, ALU and stack. The stack's clock is tied to clk by the
// integrating level, so stack strobes here are sampled on the same edge.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 8,
  parameter int unsigned IW   = 16
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [PC_W-1:0] instr_addr,
  input  logic [IW-1:0]   instr_data,
  output logic [4:0]      alu_sel,
  output logic            reg_sel,
  output logic            reg_we,
  output logic [7:0]      reg_din,
  output logic            stack_push,
  output logic            stack_pop,
  output logic [7:0]      stack_din,
  input  logic [7:0]      alu_output,
  input  logic            alu_carry,
  input  logic            stack_full,
  input  logic            stack_empty,
  input  logic [7:0]      stack_dout,
  output logic            halted,
  output logic            error,
  output logic [1:0]      err_code
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [IW-1:0]   ir_q;
  logic [7:0]      acc_q;
  logic            cf_q;
  logic            halted_q;
  logic            error_q;
  logic [1:0]      err_code_q;

  ctrl_t           ctrl;
  logic            push_op;
  logic            ovf;
  logic            unf;
  logic            take_jump;
  logic [1:0]      fault_code;

  instr_decoder #(
    .IW(IW)
  ) u_decoder (
    .ir  (ir_q),
    .ctrl(ctrl)
  );

  assign push_op    = (ctrl.op == OpPushi) || (ctrl.op == OpPusha);
  assign ovf        = push_op && stack_full;
  assign unf        = (ctrl.op == OpPop) && stack_empty;
  assign take_jump  = (ctrl.op == OpJmp) || ((ctrl.op == OpJc) && cf_q);

  // Fault cause priority: illegal opcode first, then stack faults
  always_comb begin
    fault_code = ErrNone;
    if (ctrl.illegal) begin
      fault_code = ErrIllegal;
    end else if (ovf) begin
      fault_code = ErrOverflow;
    end else if (unf) begin
      fault_code = ErrUnderflow;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; HALT and ERROR only leave through reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExec;
      StExec: begin
        if (fault_code != ErrNone) begin
          state_d = StError;
        end else if (ctrl.op == OpHalt) begin
          state_d = StHalt;
        end else begin
          state_d = StFetch;
        end
      end
      StHalt:   state_d = StHalt;
      StError:  state_d = StError;
      default:  state_d = StFetch;
    endcase
  end

  // Outputs; strobes only in EXEC, suppressed when the stack would fault
  always_comb begin
    reg_sel    = 1'b0;
    reg_we     = 1'b0;
    reg_din    = 8'h00;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    stack_din  = 8'h00;
    if (state_q == StExec) begin
      case (ctrl.op)
        OpLdi: begin
          reg_sel = ctrl.rsel;
          reg_din = ctrl.imm;
          reg_we  = 1'b1;
        end
        OpPushi: begin
          if (!stack_full) begin
            stack_din  = ctrl.imm;
            stack_push = 1'b1;
          end
        end
        OpPusha: begin
          if (!stack_full) begin
            stack_din  = acc_q;
            stack_push = 1'b1;
          end
        end
        OpPop: begin
          if (!stack_empty) begin
            reg_sel   = ctrl.rsel;
            reg_din   = stack_dout;
            reg_we    = 1'b1;
            stack_pop = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ALU select tracks IR in every state so the ALU sees stable inputs
  assign alu_sel    = ctrl.alu_fn;
  assign instr_addr = pc_q;
  assign halted     = halted_q;
  assign error      = error_q;
  assign err_code   = err_code_q;

  // Datapath registers: PC, IR, accumulator, carry and sticky status
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q       <= '0;
      ir_q       <= '0;
      acc_q      <= 8'h00;
      cf_q       <= 1'b0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      if (state_q == StDecode) begin
        ir_q <= instr_data;
        pc_q <= pc_q + PC_W'(1);
      end
      if (state_q == StExec) begin
        if (ctrl.op == OpAlu) begin
          acc_q <= alu_output;
          cf_q  <= alu_carry;
        end
        // Jump target replaces the increment already applied in DECODE
        if (take_jump) begin
          pc_q <= PC_W'(ctrl.imm);
        end
        if (state_d == StHalt) begin
          halted_q <= 1'b1;
        end
        if (state_d == StError) begin
          error_q    <= 1'b1;
          err_code_q <= fault_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an ISA-level interpreter predicts
// fetch addresses and strobe events; a monitor compares them to the DUT.
module tb_control_unit;

  localparam int PC_W  = 8;
  localparam int IW    = 16;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rstn;
  logic [PC_W-1:0] instr_addr;
  logic [IW-1:0]   instr_data;
  logic [4:0]      alu_sel;
  logic            reg_sel;
  logic            reg_we;
  logic [7:0]      reg_din;
  logic            stack_push;
  logic            stack_pop;
  logic [7:0]      stack_din;
  logic [7:0]      alu_output;
  logic            alu_carry;
  logic            stack_full;
  logic            stack_empty;
  logic [7:0]      stack_dout;
  logic            halted;
  logic            error;
  logic [1:0]      err_code;

  control_unit #(
    .PC_W(PC_W),
    .IW  (IW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .alu_sel    (alu_sel),
    .reg_sel    (reg_sel),
    .reg_we     (reg_we),
    .reg_din    (reg_din),
    .stack_push (stack_push),
    .stack_pop  (stack_pop),
    .stack_din  (stack_din),
    .alu_output (alu_output),
    .alu_carry  (alu_carry),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_dout (stack_dout),
    .halted     (halted),
    .error      (error),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Synchronous program ROM
  logic [15:0] mem [256];
  always @(posedge clk) instr_data <= mem[instr_addr];

  // Stand-in ALU: function 1 is "ADD" giving 0xFF with carry
  function automatic logic [8:0] alu_model(input logic [4:0] f);
    logic [7:0] r;
    if (f == 5'h01) return {1'b1, 8'hFF};
    r = {3'b000, f} * 8'd37 + 8'd11;
    return {f[1], r};
  endfunction
  assign {alu_carry, alu_output} = alu_model(alu_sel);

  // Stand-in stack of DEPTH entries
  logic [7:0] stk [DEPTH];
  int sp;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sp <= 0;
    end else if (stack_push && sp < DEPTH) begin
      stk[sp] <= stack_din;
      sp      <= sp + 1;
    end else if (stack_pop && sp > 0) begin
      sp <= sp - 1;
    end
  end
  assign stack_full  = (sp == DEPTH);
  assign stack_empty = (sp == 0);
  assign stack_dout  = (sp > 0) ? stk[sp-1] : 8'h00;

  typedef struct {
    int         cyc;
    bit         we;
    bit         sel;
    logic [7:0] din;
    bit         push;
    bit         pop;
    logic [7:0] sdin;
  } ev_t;

  ev_t exp_ev[$];
  int  exp_addr[$];
  int  m_term;    // 0 running, 1 halted, 2 error
  int  m_code;
  int  m_pc;
  int  m_ninstr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rsel, input int imm);
    return {op[3:0], 3'b000, rsel[0], imm[7:0]};
  endfunction

  // Instruction-level interpreter: instruction k fetches in cycle 3k+1 and
  // executes in cycle 3k+3, counting from the first cycle after reset.
  task automatic model_run(input int n);
    int         pc;
    logic [7:0] acc;
    bit         cf;
    logic [7:0] st[$];
    logic [15:0] w;
    logic [8:0] r;
    int         op;
    ev_t        e;
    pc = 0; acc = 0; cf = 0;
    m_term = 0; m_code = 0; m_ninstr = n;
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(pc);
      w  = mem[pc];
      pc = (pc + 1) % 256;
      op = int'(w[15:12]);
      e  = '{cyc: 3 * k + 3, we: 0, sel: 0, din: 0, push: 0, pop: 0, sdin: 0};
      case (op)
        0: ;
        1: begin
          e.we = 1; e.sel = w[8]; e.din = w[7:0];
          exp_ev.push_back(e);
        end
        2: begin
          r = alu_model(w[4:0]);
          acc = r[7:0]; cf = r[8];
        end
        3, 4: begin
          if (st.size() >= DEPTH) begin
            m_term = 2; m_code = 1;
          end else begin
            e.push = 1; e.sdin = (op == 3) ? w[7:0] : acc;
            st.push_back(e.sdin);
            exp_ev.push_back(e);
          end
        end
        5: begin
          if (st.size() == 0) begin
            m_term = 2; m_code = 2;
          end else begin
            e.we = 1; e.pop = 1; e.sel = w[8]; e.din = st[$];
            void'(st.pop_back());
            exp_ev.push_back(e);
          end
        end
        6: pc = int'(w[7:0]);
        7: if (cf) pc = int'(w[7:0]);
        8: m_term = 1;
        default: begin
          m_term = 2; m_code = 3;
        end
      endcase
      if (m_term != 0) begin
        m_pc = pc;
        m_ninstr = k + 1;
        return;
      end
    end
    m_pc = pc;
  endtask

  // Monitor: compares fetch addresses and strobe events against the model
  bit mon_en = 0;
  int mon_limit = 0;
  int mcyc = 0;
  ev_t mev;
  int  maddr;
  always @(negedge clk) begin
    if (!rstn) begin
      mcyc = 0;
    end else if (mon_en) begin
      mcyc++;
      if (mcyc <= mon_limit) begin
        if (mcyc % 3 == 1 && exp_addr.size() > 0) begin
          maddr = exp_addr.pop_front();
          chk("fetch_addr", 32'(instr_addr), maddr);
        end
        if (reg_we || stack_push || stack_pop ||
            (exp_ev.size() > 0 && exp_ev[0].cyc == mcyc)) begin
          if (exp_ev.size() == 0) begin
            chk("unexpected_strobe", {29'b0, reg_we, stack_push, stack_pop}, 0);
          end else begin
            mev = exp_ev.pop_front();
            chk("strobe_cycle", mcyc, mev.cyc);
            chk("reg_we", 32'(reg_we), 32'(mev.we));
            chk("stack_push", 32'(stack_push), 32'(mev.push));
            chk("stack_pop", 32'(stack_pop), 32'(mev.pop));
            if (mev.we) begin
              chk("reg_sel", 32'(reg_sel), 32'(mev.sel));
              chk("reg_din", 32'(reg_din), 32'(mev.din));
            end
            if (mev.push) chk("stack_din", 32'(stack_din), 32'(mev.sdin));
          end
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Reset, check the reset state, release one tick after a rising edge
  task automatic do_reset();
    mon_en = 0;
    rstn   = 1'b0;
    @(negedge clk);
    chk("rst_instr_addr", 32'(instr_addr), 0);
    chk("rst_strobes", {29'b0, reg_we, stack_push, stack_pop}, 0);
    chk("rst_status", {28'b0, halted, error, err_code}, 0);
    chk("rst_alu_sel", 32'(alu_sel), 0);
    chk("rst_data", {15'b0, reg_sel, reg_din, stack_din}, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic run_prog(input int n);
    exp_ev.delete();
    exp_addr.delete();
    model_run(n);
    mon_limit = (m_term != 0) ? 32'h3fff_ffff : 3 * n;
    do_reset();
    mon_en = 1;
    repeat (3 * m_ninstr + 1) @(posedge clk);
    @(negedge clk);
    #1;
    chk("events_left", exp_ev.size(), 0);
    chk("addrs_left", exp_addr.size(), 0);
    if (m_term != 0) begin
      chk("halted", 32'(halted), (m_term == 1) ? 1 : 0);
      chk("error", 32'(error), (m_term == 2) ? 1 : 0);
      chk("err_code", 32'(err_code), m_code);
      chk("frozen_pc", 32'(instr_addr), m_pc);
      repeat (10) @(posedge clk);
      #1;
      chk("frozen_pc_later", 32'(instr_addr), m_pc);
      chk("status_later", {30'b0, halted, error},
          (m_term == 1) ? 2 : 1);
    end
  endtask

  int r;
  initial begin
    rstn = 1'b0;
    clear_mem();

    // LDI r0,0x5A ; LDI r1,0x03 ; HALT
    mem[0] = enc(1, 0, 'h5A); mem[1] = enc(1, 1, 'h03); mem[2] = enc(8, 0, 0);
    run_prog(8);

    // ALU ADD -> CF=1, JC 0x10 taken, PUSHA pushes 0xFF, HALT
    clear_mem();
    mem[0] = enc(2, 0, 'h01); mem[1] = enc(7, 0, 'h10); mem[2] = enc(8, 0, 0);
    mem[16] = enc(4, 0, 0); mem[17] = enc(8, 0, 0);
    run_prog(8);

    // ALU with CF=0, JC not taken
    clear_mem();
    mem[0] = enc(2, 0, 'h00); mem[1] = enc(7, 0, 'h20); mem[2] = enc(8, 0, 0);
    run_prog(8);

    // Fill stack, then PUSHI 0x77 overflows
    clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = enc(3, 0, i + 1);
    mem[DEPTH] = enc(3, 0, 'h77);
    run_prog(10);

    // POP r1 on empty stack
    clear_mem();
    mem[0] = enc(5, 1, 0);
    run_prog(4);

    // PUSHI 0x42 ; POP r1 ; HALT
    clear_mem();
    mem[0] = enc(3, 0, 'h42); mem[1] = enc(5, 1, 0); mem[2] = enc(8, 0, 0);
    run_prog(6);

    // Illegal opcode 0xC
    clear_mem();
    mem[0] = 16'hC000;
    run_prog(4);

    // Bare HALT
    clear_mem();
    mem[0] = enc(8, 0, 0);
    run_prog(4);

    // JMP 0xFF ; NOP at 0xFF wraps PC to 0
    clear_mem();
    mem[0] = enc(6, 0, 'hFF);
    run_prog(5);

    // Reset asserted during EXEC of PUSHI aborts the push at once
    clear_mem();
    mem[0] = enc(3, 0, 'h77);
    do_reset();
    repeat (3) @(negedge clk);
    chk("push_before_reset", 32'(stack_push), 1);
    #1 rstn = 1'b0;
    #1;
    chk("push_in_reset", 32'(stack_push), 0);
    chk("pc_in_reset", 32'(instr_addr), 0);

    // Random programs
    for (int t = 0; t < 30; t++) begin
      clear_mem();
      for (int i = 0; i < 32; i++) begin
        r = $urandom_range(0, 99);
        if (r < 15)      mem[i] = enc(1, $urandom_range(0, 1), $urandom_range(0, 255));
        else if (r < 30) mem[i] = enc(2, 0, $urandom_range(0, 31));
        else if (r < 45) mem[i] = enc(3, 0, $urandom_range(0, 255));
        else if (r < 55) mem[i] = enc(4, 0, 0);
        else if (r < 70) mem[i] = enc(5, $urandom_range(0, 1), 0);
        else if (r < 78) mem[i] = enc(6, 0, $urandom_range(0, 40));
        else if (r < 88) mem[i] = enc(7, 0, $urandom_range(0, 40));
        else if (r < 90) mem[i] = enc(8, 0, 0);
        else if (r < 92) mem[i] = enc($urandom_range(9, 15), 0, 0);
        else             mem[i] = enc(0, 0, 0);
        // Reserved bits must not affect decoding
        mem[i][11:9] = 3'($urandom_range(0, 7));
      end
      run_prog(40);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
